// File: rtl/nx_ram_1rw_hw_arbiter.sv
// Round-robin arbiter sharing the hardware port of a 1RW indirect-access RAM
// wrapper between N_REQ requesters. Accepted reads are tagged and hw_dout is
// routed back to the issuing requester after RD_LATENCY cycles. A starvation
// guard inserts an idle hardware cycle so a waiting software access can win.
module nx_ram_1rw_hw_arbiter #(
  parameter int N_REQ        = 3,
  parameter int N_ADDR_BITS  = 14,
  parameter int N_DATA_BITS  = 38,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ-1:0]               req_we,
  input  logic [N_REQ*N_ADDR_BITS-1:0]   req_addr,
  input  logic [N_REQ*N_DATA_BITS-1:0]   req_wdat,
  input  logic [N_REQ*N_DATA_BITS-1:0]   req_bwe,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [N_DATA_BITS-1:0]         rsp_dat,
  input  logic                           sw_pend,
  output logic                           hw_cs,
  output logic                           hw_we,
  output logic [N_ADDR_BITS-1:0]         hw_add,
  output logic [N_DATA_BITS-1:0]         hw_din,
  output logic [N_DATA_BITS-1:0]         hw_bwe,
  input  logic [N_DATA_BITS-1:0]         hw_dout,
  output logic                           starve_evt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RUN_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STARVE_LIMIT);
  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

  logic [IDX_W-1:0]       last_gnt_q;
  logic [RUN_W-1:0]       hw_run_q;
  logic                   hw_cs_q;
  logic                   hw_we_q;
  logic [IDX_W-1:0]       hw_id_q;
  logic [N_ADDR_BITS-1:0] hw_add_q;
  logic [N_DATA_BITS-1:0] hw_din_q;
  logic [N_DATA_BITS-1:0] hw_bwe_q;
  logic [RD_LATENCY-1:0]  pipe_vld_q;
  logic [IDX_W-1:0]       pipe_id_q [RD_LATENCY];

  logic                   gnt_vld;
  logic [IDX_W-1:0]       gnt_id_d;
  logic                   sel_we_d;
  logic [N_ADDR_BITS-1:0] sel_add_d;
  logic [N_DATA_BITS-1:0] sel_din_d;
  logic [N_DATA_BITS-1:0] sel_bwe_d;
  logic                   force_idle;
  logic                   xfer;

  // Stage 0: round-robin search starting one past the last granted requester
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id_d = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!gnt_vld && req_valid[(int'(last_gnt_q) + k) % N_REQ]) begin
        gnt_vld  = 1'b1;
        gnt_id_d = IDX_W'((int'(last_gnt_q) + k) % N_REQ);
      end
    end
  end

  // Select the granted requester's command fields from the packed buses
  always_comb begin
    sel_we_d  = 1'b0;
    sel_add_d = '0;
    sel_din_d = '0;
    sel_bwe_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == gnt_id_d) begin
        sel_we_d  = req_we[i];
        sel_add_d = req_addr[i*N_ADDR_BITS +: N_ADDR_BITS];
        sel_din_d = req_wdat[i*N_DATA_BITS +: N_DATA_BITS];
        sel_bwe_d = req_bwe[i*N_DATA_BITS +: N_DATA_BITS];
      end
    end
  end

  // A full run of hardware cycles against a waiting software access forces
  // one idle arbitration cycle; ready is held low during reset.
  assign force_idle = (hw_run_q == RUN_LIMIT);
  assign xfer       = gnt_vld & ~force_idle & ~rst;
  assign req_ready  = xfer ? (ONE_HOT0 << gnt_id_d) : '0;
  assign starve_evt = force_idle;

  // Priority pointer moves only when a request is actually accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= IDX_W'(N_REQ - 1);
    end else if (xfer) begin
      last_gnt_q <= gnt_id_d;
    end
  end

  // Count consecutive hardware transfers while software is waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_run_q <= '0;
    end else if (force_idle || !sw_pend) begin
      hw_run_q <= '0;
    end else if (xfer) begin
      hw_run_q <= hw_run_q + RUN_W'(1);
    end
  end

  // Stage 1: register the accepted command onto the RAM hardware port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_cs_q  <= 1'b0;
      hw_we_q  <= 1'b0;
      hw_id_q  <= '0;
      hw_add_q <= '0;
      hw_din_q <= '0;
      hw_bwe_q <= '0;
    end else begin
      hw_cs_q <= xfer;
      hw_we_q <= xfer & sel_we_d;
      if (xfer) begin
        hw_id_q  <= gnt_id_d;
        hw_add_q <= sel_add_d;
        hw_din_q <= sel_din_d;
        hw_bwe_q <= sel_bwe_d;
      end
    end
  end

  // Stage 2..: carry read tags alongside the RAM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipe_id_q[s] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= hw_cs_q & ~hw_we_q;
      pipe_id_q[0]  <= hw_id_q;
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_id_q[s]  <= pipe_id_q[s-1];
      end
    end
  end

  assign rsp_valid = pipe_vld_q[RD_LATENCY-1] ? (ONE_HOT0 << pipe_id_q[RD_LATENCY-1]) : '0;
  assign rsp_dat   = hw_dout;

  assign hw_cs  = hw_cs_q;
  assign hw_we  = hw_we_q;
  assign hw_add = hw_add_q;
  assign hw_din = hw_din_q;
  assign hw_bwe = hw_bwe_q;

endmodule

// File: tb/tb_nx_ram_1rw_hw_arbiter.sv
// Directed bench for nx_ram_1rw_hw_arbiter with a behavioural 1-cycle RAM.
module tb_nx_ram_1rw_hw_arbiter;

  localparam int NR = 3;
  localparam int AW = 14;
  localparam int DW = 38;

  logic               clk;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR-1:0]      req_we;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_wdat;
  logic [NR*DW-1:0]   req_bwe;
  logic [NR-1:0]      rsp_valid;
  logic [DW-1:0]      rsp_dat;
  logic               sw_pend;
  logic               hw_cs;
  logic               hw_we;
  logic [AW-1:0]      hw_add;
  logic [DW-1:0]      hw_din;
  logic [DW-1:0]      hw_bwe;
  logic [DW-1:0]      hw_dout;
  logic               starve_evt;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] a_tab [3];
  logic [DW-1:0] w_tab [3];

  nx_ram_1rw_hw_arbiter #(
    .N_REQ(NR), .N_ADDR_BITS(AW), .N_DATA_BITS(DW), .RD_LATENCY(1), .STARVE_LIMIT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdat(req_wdat), .req_bwe(req_bwe),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .sw_pend(sw_pend),
    .hw_cs(hw_cs), .hw_we(hw_we), .hw_add(hw_add), .hw_din(hw_din),
    .hw_bwe(hw_bwe), .hw_dout(hw_dout), .starve_evt(starve_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: preloaded words at a few addresses, one-cycle read
  bit [DW-1:0] mem     [0:(1<<AW)-1];
  bit          written [0:(1<<AW)-1];
  logic [DW-1:0] dout_q;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    case (a)
      14'd10:  return 38'h0A11112222;
      14'd20:  return 38'h1433334444;
      14'd30:  return 38'h1E55556666;
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (hw_cs) begin
      if (hw_we) begin
        mem[hw_add]     <= ((written[hw_add] ? mem[hw_add] : init_word(hw_add)) & ~hw_bwe)
                           | (hw_din & hw_bwe);
        written[hw_add] <= 1'b1;
      end else begin
        dout_q <= written[hw_add] ? mem[hw_add] : init_word(hw_add);
      end
    end
  end
  assign hw_dout = dout_q;

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] be);
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdat[i*DW +: DW] = wd;
    req_bwe[i*DW +: DW]  = be;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++; if (hw_cs !== 1'b0 || hw_we !== 1'b0) begin errors++; $display("FAIL reset_cs_we got=%b%b exp=00", hw_cs, hw_we); end
    checks++; if (hw_add !== '0 || hw_din !== '0 || hw_bwe !== '0) begin errors++; $display("FAIL reset_data got add=%h din=%h bwe=%h exp=0", hw_add, hw_din, hw_bwe); end
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp got=%b exp=000", rsp_valid); end
    checks++; if (starve_evt !== 1'b0) begin errors++; $display("FAIL reset_starve got=%b exp=0", starve_evt); end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 3'b000;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, a_tab[i], '0, '0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = (c < 6) ? 3'b111 : 3'b000;
      #1;
      checks++;
      if (req_ready !== ((c < 6) ? (3'b001 << (c % 3)) : 3'b000)) begin
        errors++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, (c < 6) ? (3'b001 << (c % 3)) : 3'b000);
      end
      checks++;
      if (hw_cs !== ((c >= 1) && (c <= 6))) begin
        errors++; $display("FAIL rr_hw_cs c=%0d got=%b", c, hw_cs);
      end
      if (c >= 1 && c <= 6) begin
        checks++;
        if (hw_add !== a_tab[(c-1) % 3] || hw_we !== 1'b0) begin
          errors++; $display("FAIL rr_hw_add c=%0d got=%h exp=%h we=%b", c, hw_add, a_tab[(c-1) % 3], hw_we);
        end
      end
      checks++;
      if (rsp_valid !== ((c >= 2) ? (3'b001 << ((c-2) % 3)) : 3'b000)) begin
        errors++; $display("FAIL rr_rsp_valid c=%0d got=%b", c, rsp_valid);
      end
      if (c >= 2) begin
        checks++;
        if (rsp_dat !== w_tab[(c-2) % 3]) begin
          errors++; $display("FAIL rr_rsp_dat c=%0d got=%h exp=%h", c, rsp_dat, w_tab[(c-2) % 3]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    set_req(1, 1'b1, 14'h0123, 38'h15A5A5A5A5, {DW{1'b1}});
    set_req(2, 1'b0, 14'h0123, '0, '0);
    @(negedge clk);
    req_valid = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL wr_ready got=%b exp=010", req_ready); end
    @(negedge clk);
    req_valid = 3'b100;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL rd_ready got=%b exp=100", req_ready); end
    checks++;
    if (hw_cs !== 1'b1 || hw_we !== 1'b1 || hw_add !== 14'h0123 || hw_din !== 38'h15A5A5A5A5 || hw_bwe !== {DW{1'b1}}) begin
      errors++; $display("FAIL wr_issue got cs=%b we=%b add=%h din=%h bwe=%h", hw_cs, hw_we, hw_add, hw_din, hw_bwe);
    end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    checks++; if (hw_cs !== 1'b1 || hw_we !== 1'b0) begin errors++; $display("FAIL rd_issue got cs=%b we=%b exp cs=1 we=0", hw_cs, hw_we); end
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL wr_no_rsp got=%b exp=000", rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 3'b100) begin errors++; $display("FAIL rd_rsp_valid got=%b exp=100", rsp_valid); end
    checks++; if (rsp_dat !== 38'h15A5A5A5A5) begin errors++; $display("FAIL rd_rsp_dat got=%h exp=15a5a5a5a5", rsp_dat); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL rd_rsp_single got=%b exp=000", rsp_valid); end
    set_req(1, 1'b0, a_tab[1], '0, '0);
    set_req(2, 1'b0, a_tab[2], '0, '0);
  endtask

  task automatic test_wrap_hold();
    // last grant is requester 2 here
    @(negedge clk);
    req_valid = 3'b100;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL wrap_ready got=%b exp=100", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    checks++; if (req_ready !== 3'b000 || hw_cs !== 1'b1) begin errors++; $display("FAIL wrap_gap got ready=%b cs=%b exp 000/1", req_ready, hw_cs); end
    @(negedge clk);
    req_valid = 3'b011;
    #1;
    checks++; if (hw_cs !== 1'b0) begin errors++; $display("FAIL wrap_idle_cs got=%b exp=0", hw_cs); end
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL wrap_keep_ptr got=%b exp=001", req_ready); end
    checks++; if (rsp_valid !== 3'b100 || rsp_dat !== 38'h1E55556666) begin errors++; $display("FAIL wrap_rsp got v=%b d=%h exp 100/1e55556666", rsp_valid, rsp_dat); end
    @(negedge clk);
    req_valid = 3'b011;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL wrap_next got=%b exp=010", req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 3'b000;
    end
  endtask

  task automatic test_starve();
    sw_pend = 1'b1;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      req_valid = 3'b001;
      #1;
      checks++;
      if (req_ready !== ((c == 16 || c == 33) ? 3'b000 : 3'b001)) begin
        errors++; $display("FAIL starve_ready c=%0d got=%b", c, req_ready);
      end
      checks++;
      if (starve_evt !== (c == 16 || c == 33)) begin
        errors++; $display("FAIL starve_evt c=%0d got=%b", c, starve_evt);
      end
      checks++;
      if (hw_cs !== (c != 0 && c != 17 && c != 34)) begin
        errors++; $display("FAIL starve_hw_cs c=%0d got=%b", c, hw_cs);
      end
    end
    @(negedge clk);
    req_valid = 3'b000;
    sw_pend = 1'b0;
  endtask

  task automatic test_sw_toggle();
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      req_valid = 3'b001;
      sw_pend = (c == 10) ? 1'b0 : 1'b1;
      #1;
      checks++;
      if (req_ready !== ((c == 27) ? 3'b000 : 3'b001) || starve_evt !== (c == 27)) begin
        errors++; $display("FAIL toggle_guard c=%0d got ready=%b evt=%b", c, req_ready, starve_evt);
      end
    end
    @(negedge clk);
    req_valid = 3'b000;
    sw_pend = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 3'b111;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b000 || hw_cs !== 1'b0 || rsp_valid !== 3'b000) begin errors++; $display("FAIL rstmid_in_rst got ready=%b cs=%b rsp=%b", req_ready, hw_cs, rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 3'b000 || rsp_valid !== 3'b000) begin errors++; $display("FAIL rstmid_hold got ready=%b rsp=%b", req_ready, rsp_valid); end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 3'b000;
    #1;
    checks++;
    if (hw_cs !== 1'b0 || hw_we !== 1'b0 || hw_add !== '0 || hw_din !== '0 || hw_bwe !== '0 || rsp_valid !== 3'b000 || starve_evt !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got cs=%b we=%b add=%h din=%h bwe=%h rsp=%b evt=%b", hw_cs, hw_we, hw_add, hw_din, hw_bwe, rsp_valid, starve_evt);
    end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 3'b000 || hw_cs !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp got rsp=%b cs=%b", rsp_valid, hw_cs); end
    @(negedge clk);
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rstmid_first_grant got=%b exp=001", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
  endtask

  initial begin
    a_tab[0] = 14'd10; a_tab[1] = 14'd20; a_tab[2] = 14'd30;
    w_tab[0] = 38'h0A11112222; w_tab[1] = 38'h1433334444; w_tab[2] = 38'h1E55556666;
    rst = 1'b1;
    sw_pend = 1'b0;
    req_valid = '0;
    req_we = '0;
    req_addr = '0;
    req_wdat = '0;
    req_bwe = '0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_wrap_hold();
    test_starve();
    test_sw_toggle();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
